// File: rtl/vic_wb_buffer.sv
// Victim-cache writeback buffer: circular FIFO of evicted dirty lines that
// drains to memory as stores, with a combinational forwarding lookup and flush.
module vic_wb_buffer #(
  parameter int DEPTH        = 4,
  parameter int NUM_SET_BITS = 4,
  parameter int NUM_TAG_BITS = 8,
  localparam int LINE_W      = 1 + NUM_TAG_BITS + 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fired_valid,
  input  logic [LINE_W-1:0]       fired_victim,
  input  logic [NUM_SET_BITS-1:0] fired_set_index,
  output logic                    in_ready,
  input  logic [NUM_TAG_BITS-1:0] rd_tag,
  input  logic [NUM_SET_BITS-1:0] rd_set_index,
  output logic                    rd_hit,
  output logic [63:0]             rd_data,
  output logic [1:0]              proc2mem_command,
  output logic [63:0]             proc2mem_addr,
  output logic [63:0]             proc2mem_data,
  input  logic [3:0]              mem2proc_response,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    empty
);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PAD = 64 - NUM_TAG_BITS - NUM_SET_BITS - 3;

  typedef struct packed {
    logic                    valid;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [63:0]             data;
  } CACHE_LINE_T;

  typedef struct packed {
    logic                    valid;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] set_index;
    logic [63:0]             data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  CACHE_LINE_T   line;
  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          flush_done_q, flush_done_d;
  logic          storing;
  logic          push;
  logic          pop;

  assign line     = fired_victim;
  assign storing  = (state_q != IDLE);
  assign in_ready = !reset && (state_q != FLUSH)
                    && (count_q < CW'(DEPTH));
  assign push     = fired_valid && in_ready;
  assign pop      = storing && (mem2proc_response != 4'h0);

  assign proc2mem_command = storing ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = storing ?
    {{PAD{1'b0}}, ent_q[head_q].tag, ent_q[head_q].set_index, 3'b000}
    : 64'h0;
  assign proc2mem_data    = storing ? ent_q[head_q].data : 64'h0;
  assign empty            = (count_q == '0);
  assign flush_done       = flush_done_q;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push) begin
      ent_d[tail_q].valid     = line.valid;
      ent_d[tail_q].tag       = line.tag;
      ent_d[tail_q].set_index = fired_set_index;
      ent_d[tail_q].data      = line.data;
      tail_d = tail_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A flush request in any state ends once the post-update count is zero.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    if ((state_q == FLUSH) || flush_req) begin
      if (count_d == '0) begin
        state_d      = IDLE;
        flush_done_d = 1'b1;
      end else begin
        state_d = FLUSH;
      end
    end else begin
      unique case (state_q)
        IDLE:    if (count_q != '0) state_d = SEND;
        SEND:    if (count_d == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    rd_hit  = 1'b0;
    rd_data = 64'h0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (ent_q[idx].valid && (ent_q[idx].tag == rd_tag)
          && (ent_q[idx].set_index == rd_set_index)) begin
        rd_hit  = 1'b1;
        rd_data = ent_q[idx].data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      flush_done_q <= 1'b0;
    end else begin
      ent_q        <= ent_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_vic_wb_buffer.sv
// Directed bench for vic_wb_buffer: a per-cycle vector table plus
// hand sequences for fill/backpressure, flush and mid-store reset.
module tb_vic_wb_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        fired_valid;
  logic [72:0] fired_victim;
  logic [3:0]  fired_set_index;
  logic        in_ready;
  logic [7:0]  rd_tag;
  logic [3:0]  rd_set_index;
  logic        rd_hit;
  logic [63:0] rd_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic        flush_req;
  logic        flush_done;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vic_wb_buffer #(.DEPTH(4), .NUM_SET_BITS(4), .NUM_TAG_BITS(8)) dut (
    .clock(clock),
    .reset(reset),
    .fired_valid(fired_valid),
    .fired_victim(fired_victim),
    .fired_set_index(fired_set_index),
    .in_ready(in_ready),
    .rd_tag(rd_tag),
    .rd_set_index(rd_set_index),
    .rd_hit(rd_hit),
    .rd_data(rd_data),
    .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response),
    .flush_req(flush_req),
    .flush_done(flush_done),
    .empty(empty)
  );

  typedef struct {
    logic        push;
    logic [7:0]  tag;
    logic [3:0]  set;
    logic [63:0] data;
    logic [3:0]  resp;
    logic [7:0]  rtag;
    logic [3:0]  rset;
    logic        store;
    logic [63:0] eaddr;
    logic [63:0] edata;
    logic        emp;
    logic        hit;
    logic [63:0] rdata;
  } vec_t;

  vec_t vt [17];

  function automatic logic [63:0] addr_of(input logic [7:0] t,
                                          input logic [3:0] s);
    return {49'h0, t, s, 3'b000};
  endfunction

  function automatic vec_t mk(
    input logic push, input logic [7:0] tag, input logic [3:0] set,
    input logic [63:0] data, input logic [3:0] resp,
    input logic [7:0] rtag, input logic [3:0] rset,
    input logic store, input logic [63:0] eaddr, input logic [63:0] edata,
    input logic emp, input logic hit, input logic [63:0] rdata);
    vec_t v;
    v.push = push; v.tag = tag; v.set = set; v.data = data;
    v.resp = resp; v.rtag = rtag; v.rset = rset; v.store = store;
    v.eaddr = eaddr; v.edata = edata; v.emp = emp; v.hit = hit;
    v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] t,
                     input logic [3:0] s, input logic [63:0] d);
    fired_valid     = v;
    fired_victim    = {1'b1, t, d};
    fired_set_index = s;
  endtask

  task automatic chk_store(input string nm, input logic [63:0] a,
                           input logic [63:0] d);
    chk({nm, " cmd"}, 64'(proc2mem_command), 64'h2);
    chk({nm, " addr"}, proc2mem_addr, a);
    chk({nm, " data"}, proc2mem_data, d);
  endtask

  initial begin
    logic [63:0] a56;
    a56 = addr_of(8'h56, 4'h7);
    vt[0]  = mk(1, 8'h12, 4'h3, 64'hDEAD, 0, 8'h12, 4'h3,
                0, 0, 0, 1, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 8'h12, 4'h3, 0, 0, 0, 0, 1, 64'hDEAD);
    vt[2]  = mk(0, 0, 0, 0, 1, 8'h12, 4'h3,
                1, 64'h918, 64'hDEAD, 0, 1, 64'hDEAD);
    vt[3]  = mk(0, 0, 0, 0, 0, 8'h12, 4'h3, 0, 0, 0, 1, 0, 0);
    vt[4]  = mk(1, 8'h34, 4'h5, 64'hBEEF, 0, 8'hFF, 4'hF,
                0, 0, 0, 1, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 8'h34, 4'h5, 0, 0, 0, 0, 1, 64'hBEEF);
    vt[6]  = mk(0, 0, 0, 0, 0, 8'hFF, 4'hF,
                1, 64'h1A28, 64'hBEEF, 0, 0, 0);
    vt[7]  = vt[6];
    vt[8]  = vt[6];
    vt[9]  = mk(0, 0, 0, 0, 2, 8'hFF, 4'hF,
                1, 64'h1A28, 64'hBEEF, 0, 0, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 8'hFF, 4'hF, 0, 0, 0, 1, 0, 0);
    vt[11] = mk(1, 8'h56, 4'h7, 64'hA, 0, 8'h56, 4'h7,
                0, 0, 0, 1, 0, 0);
    vt[12] = mk(1, 8'h56, 4'h7, 64'hB, 0, 8'h56, 4'h7,
                0, 0, 0, 0, 1, 64'hA);
    vt[13] = mk(0, 0, 0, 0, 0, 8'h56, 4'h7, 1, a56, 64'hA, 0, 1, 64'hB);
    vt[14] = mk(0, 0, 0, 0, 1, 8'h56, 4'h6, 1, a56, 64'hA, 0, 0, 0);
    vt[15] = mk(0, 0, 0, 0, 1, 8'h56, 4'h7, 1, a56, 64'hB, 0, 1, 64'hB);
    vt[16] = mk(0, 0, 0, 0, 0, 8'h56, 4'h7, 0, 0, 0, 1, 0, 0);

    reset = 1'b1;
    drv(0, 0, 0, 0);
    rd_tag = 8'hFF; rd_set_index = 4'hF;
    mem2proc_response = 4'h0;
    flush_req = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    chk("rst cmd", 64'(proc2mem_command), 64'h0);
    chk("rst in_ready", 64'(in_ready), 64'h0);
    chk("rst rd_hit", 64'(rd_hit), 64'h0);
    chk("rst rd_data", rd_data, 64'h0);
    chk("rst flush_done", 64'(flush_done), 64'h0);
    chk("rst empty", 64'(empty), 64'h1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post-rst in_ready", 64'(in_ready), 64'h1);

    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      drv(vt[i].push, vt[i].tag, vt[i].set, vt[i].data);
      mem2proc_response = vt[i].resp;
      rd_tag = vt[i].rtag;
      rd_set_index = vt[i].rset;
      #1;
      chk($sformatf("v%0d cmd", i), 64'(proc2mem_command),
          vt[i].store ? 64'h2 : 64'h0);
      if (vt[i].store) begin
        chk($sformatf("v%0d addr", i), proc2mem_addr, vt[i].eaddr);
        chk($sformatf("v%0d data", i), proc2mem_data, vt[i].edata);
      end
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'h1);
      chk($sformatf("v%0d empty", i), 64'(empty), 64'(vt[i].emp));
      chk($sformatf("v%0d rd_hit", i), 64'(rd_hit), 64'(vt[i].hit));
      chk($sformatf("v%0d rd_data", i), rd_data, vt[i].rdata);
      chk($sformatf("v%0d flush_done", i), 64'(flush_done), 64'h0);
    end

    // Flush with nothing pending
    @(negedge clock);
    rd_tag = 8'hFF; rd_set_index = 4'hF;
    flush_req = 1'b1;
    #1;
    chk("eflush pre", 64'(flush_done), 64'h0);
    @(negedge clock);
    flush_req = 1'b0;
    #1;
    chk("eflush pulse", 64'(flush_done), 64'h1);
    @(negedge clock);
    #1;
    chk("eflush end", 64'(flush_done), 64'h0);

    // Fill past DEPTH with memory stalled
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      drv(1, 8'h40 + 8'(k), 4'(k), 64'h100 + 64'(k));
      mem2proc_response = 4'h0;
      #1;
      chk($sformatf("fill%0d in_ready", k), 64'(in_ready),
          (k < 4) ? 64'h1 : 64'h0);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      drv(0, 0, 0, 0);
      mem2proc_response = 4'h1;
      #1;
      chk_store($sformatf("drain%0d", j),
                addr_of(8'h40 + 8'(j), 4'(j)), 64'h100 + 64'(j));
    end
    @(negedge clock);
    mem2proc_response = 4'h0;
    #1;
    chk("drain done cmd", 64'(proc2mem_command), 64'h0);
    chk("drain done empty", 64'(empty), 64'h1);

    // Flush with three entries pending
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      drv(1, 8'h60 + 8'(k), 4'h1, 64'h200 + 64'(k));
    end
    @(negedge clock);
    drv(0, 0, 0, 0);
    flush_req = 1'b1;
    mem2proc_response = 4'h1;
    #1;
    chk_store("fl0", addr_of(8'h60, 4'h1), 64'h200);
    @(negedge clock);
    flush_req = 1'b0;
    drv(1, 8'h77, 4'h2, 64'h999);
    #1;
    chk("fl1 in_ready", 64'(in_ready), 64'h0);
    chk("fl1 flush_done", 64'(flush_done), 64'h0);
    chk_store("fl1", addr_of(8'h61, 4'h1), 64'h201);
    @(negedge clock);
    drv(0, 0, 0, 0);
    #1;
    chk("fl2 in_ready", 64'(in_ready), 64'h0);
    chk_store("fl2", addr_of(8'h62, 4'h1), 64'h202);
    @(negedge clock);
    mem2proc_response = 4'h0;
    #1;
    chk("fl3 cmd", 64'(proc2mem_command), 64'h0);
    chk("fl3 flush_done", 64'(flush_done), 64'h1);
    chk("fl3 empty", 64'(empty), 64'h1);
    @(negedge clock);
    #1;
    chk("fl4 flush_done", 64'(flush_done), 64'h0);
    chk("fl4 in_ready", 64'(in_ready), 64'h1);

    // Reset while a store is outstanding
    @(negedge clock);
    drv(1, 8'h70, 4'h4, 64'h300);
    @(negedge clock);
    drv(1, 8'h71, 4'h4, 64'h301);
    @(negedge clock);
    drv(0, 0, 0, 0);
    rd_tag = 8'h70; rd_set_index = 4'h4;
    #1;
    chk_store("rs pre", addr_of(8'h70, 4'h4), 64'h300);
    #1;
    reset = 1'b1;
    #1;
    chk("rs cmd", 64'(proc2mem_command), 64'h0);
    chk("rs empty", 64'(empty), 64'h1);
    chk("rs in_ready", 64'(in_ready), 64'h0);
    chk("rs rd_hit", 64'(rd_hit), 64'h0);
    chk("rs rd_data", rd_data, 64'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    mem2proc_response = 4'h1;
    #1;
    chk("rs post in_ready", 64'(in_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("rs idle%0d cmd", k), 64'(proc2mem_command), 64'h0);
      chk($sformatf("rs idle%0d empty", k), 64'(empty), 64'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vic_wb_buffer.md
VIC_WB_BUFFER -- requirements
Module: vic_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of pending-writeback entries (power of 2, >=2).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port fired_valid  input  1  evicted dirty line presented by victim cache.
REQ-005 SHALL have port fired_victim  input  CACHE_LINE_T  evicted line (valid, tag, data).
REQ-006 SHALL have port fired_set_index  input  NUM_SET_BITS  set index of evicted line.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a push this cycle.
REQ-008 SHALL have port rd_tag / rd_set_index  input  NUM_TAG_BITS / NUM_SET_BITS  forwarding lookup key.
REQ-009 SHALL have port rd_hit  output  1  lookup key matches a pending entry.
REQ-010 SHALL have port rd_data  output  64  data of matching entry; 0 when no hit.
REQ-011 SHALL have port proc2mem_command  output  2  BUS_NONE / BUS_STORE.
REQ-012 SHALL have port proc2mem_addr  output  64  store address.
REQ-013 SHALL have port proc2mem_data  output  64  store data.
REQ-014 SHALL have port mem2proc_response  input  4  memory tag; nonzero = request accepted this cycle.
REQ-015 SHALL have port flush_req  input  1  request to drain all entries.
REQ-016 SHALL have port flush_done  output  1  one-cycle pulse when a flush completes.
REQ-017 SHALL have port empty  output  1  no pending entries.

Function
REQ-018 SHALL hold entries in a circular FIFO (head, tail, count of width clog2(DEPTH)+1); pointers wrap modulo DEPTH.
REQ-019 SHALL drive in_ready = (count < DEPTH) from registered count only; no same-cycle pop bypass.
REQ-020 SHALL push {fired_victim, fired_set_index} at tail when fired_valid && in_ready; fired_valid while !in_ready is ignored (upstream holds).
REQ-021 SHALL run FSM states IDLE, SEND, FLUSH.
REQ-022 IDLE: proc2mem_command = BUS_NONE; -> SEND when count != 0 (next cycle after push, latency 1).
REQ-023 SEND: drive BUS_STORE, addr = zero-extended {head.tag, head.set_index, 3'b000}, data = head.data; hold all three stable until accepted.
REQ-024 Acceptance: mem2proc_response != 0 while BUS_STORE driven pops head at that posedge; response 0 = retry next cycle, no pop.
REQ-025 SEND -> IDLE when popping the last entry with no same-cycle push; otherwise stay SEND and present next head the following cycle.
REQ-026 flush_req sampled high in IDLE or SEND -> FLUSH; FLUSH issues stores as SEND but in_ready SHALL be 0.
REQ-027 FLUSH -> IDLE when count reaches 0; flush_done SHALL pulse 1 cycle on that transition; flush with count 0 pulses flush_done next cycle.
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 Lookup SHALL be combinational over valid entries only; multiple matches return youngest (closest to tail).
REQ-030 An entry being popped this cycle SHALL still report rd_hit in that cycle.
REQ-031 empty = (count == 0), registered-state derived.

Reset
REQ-032 On reset assert (asynchronous): count=0, head=tail=0, FSM=IDLE, all entry valid bits 0.
REQ-033 During reset: proc2mem_command=BUS_NONE, in_ready=0, rd_hit=0, rd_data=0, flush_done=0, empty=1; in_ready=1 first cycle after deassert.
REQ-034 Reset mid-SEND SHALL discard all pending entries without completing the store.

Verification
REQ-035 Single push tag=0x12, set=0x3, data=0xDEAD, response=1 next cycle -> BUS_STORE addr={0x12,0x3,000} one cycle, then BUS_NONE, empty=1.
REQ-036 Push then response=0 for 3 cycles then 2 -> addr/data stable for 4 cycles, exactly one pop.
REQ-037 DEPTH+1 back-to-back pushes, response 0 -> in_ready=0 after 4th push, 5th ignored, 4 stores drained in order.
REQ-038 Two entries same tag/set data 0xA then 0xB, lookup -> rd_hit=1, rd_data=0xB; lookup other key -> rd_hit=0, rd_data=0.
REQ-039 3 entries + flush_req, response=1 each cycle -> in_ready=0, 3 stores, flush_done single pulse, empty=1.
REQ-040 Reset asserted mid-SEND with 2 entries -> immediately BUS_NONE, empty=1, no further stores after deassert.
